// File: rtl/fft_frame_sink_pkg.sv
// rtl/fft_frame_sink_pkg.sv - shared FSM encodings, counter width and bit-reverse helper for fft_frame_sink
package fft_frame_sink_pkg;

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    localparam int DROP_CNT_W = 8;

    // Reverses the low 'width' bits of idx (width = TOTAL_STEP); upper result bits are zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = idx;
        for (int b = 0; b < 32; b++) begin
            if (b < width) begin
                r = {r[30:0], t[0]};
                t = {1'b0, t[31:1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_sink_if.sv
// rtl/fft_frame_sink_if.sv - downstream sample stream of fft_frame_sink (valid/ready with frame markers)
interface fft_frame_sink_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  o_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_real;
    logic [DATA_WIDTH-1:0] o_imag;
    logic                  o_first;
    logic                  o_last;

    modport master (
        output o_valid, o_real, o_imag, o_first, o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid, o_real, o_imag, o_first, o_last,
        output o_ready
    );
endinterface

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame buffer bank: single write port, registered read port that holds when idle
module fft_frame_bank #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) (
    input  logic              iclk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] rdata_q;

    // rdata_q only moves on re_i, so a stalled consumer sees a stable word.
    always_ff @(posedge iclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_frame_sink.sv
// rtl/fft_frame_sink.sv - ping-pong frame buffer from FFT core to valid/ready stream; FFT_FRAME_SINK_BITREV_EN reorders bit-reversed frames
module fft_frame_sink
    import fft_frame_sink_pkg::*;
#(
    parameter int TOTAL_STEP = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  iclk,
    input  logic                  rstn,
    input  logic                  ien,
    input  logic [DATA_WIDTH-1:0] iReal,
    input  logic [DATA_WIDTH-1:0] iImag,
    fft_frame_sink_if.master      out_if,
    output logic                  ovf,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    localparam logic [TOTAL_STEP-1:0] LAST_IDX = '1;
    localparam logic [TOTAL_STEP-1:0] IDX_ONE  = TOTAL_STEP'(1);

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [TOTAL_STEP-1:0] wi_q, wi_d;
    logic [TOTAL_STEP-1:0] oidx_q, oidx_d;
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic [1:0]            full_q, full_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  we;
    logic                  re;
    logic                  wr_set;
    logic                  rd_clr;
    logic                  bank_free;
    logic [TOTAL_STEP-1:0] ridx;
    logic [TOTAL_STEP-1:0] raddr;
    logic [2*DATA_WIDTH-1:0] rdata [2];
    logic [2*DATA_WIDTH-1:0] sel_word;

    // Read side: one prefetch into the bank's read register, then advance only on transfer.
    always_comb begin
        rd_state_d = rd_state_q;
        rb_d       = rb_q;
        valid_d    = valid_q;
        oidx_d     = oidx_q;
        re         = 1'b0;
        ridx       = oidx_q;
        rd_clr     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rb_q]) begin
                    re         = 1'b1;
                    ridx       = '0;
                    oidx_d     = '0;
                    valid_d    = 1'b1;
                    rd_state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (valid_q && out_if.o_ready) begin
                    if (oidx_q == LAST_IDX) begin
                        rd_clr     = 1'b1;
                        rb_d       = ~rb_q;
                        valid_d    = 1'b0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        re     = 1'b1;
                        ridx   = oidx_q + IDX_ONE;
                        oidx_d = oidx_q + IDX_ONE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
`ifdef FFT_FRAME_SINK_BITREV_EN
        raddr = TOTAL_STEP'(bit_rev(32'(ridx), TOTAL_STEP));
`else
        raddr = ridx;
`endif
    end

    // A bank released by the reader on this edge already counts as free.
    assign bank_free = ~full_q[wb_q] | (rd_clr & (rb_q == wb_q));

    always_comb begin
        wr_state_d = wr_state_q;
        wi_d       = wi_q;
        wb_d       = wb_q;
        we         = 1'b0;
        wr_set     = 1'b0;
        ovf_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        case (wr_state_q)
            WR_FILL: begin
                if (ien) begin
                    if ((wi_q == '0) && !bank_free) begin
                        wr_state_d = WR_DROP;
                        ovf_d      = 1'b1;
                        wi_d       = wi_q + IDX_ONE;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                        end
                    end else begin
                        we = 1'b1;
                        if (wi_q == LAST_IDX) begin
                            wr_set = 1'b1;
                            wb_d   = ~wb_q;
                            wi_d   = '0;
                        end else begin
                            wi_d = wi_q + IDX_ONE;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (ien) begin
                    if (wi_q == LAST_IDX) begin
                        wr_state_d = WR_FILL;
                        wi_d       = '0;
                    end else begin
                        wi_d = wi_q + IDX_ONE;
                    end
                end
            end
            default: wr_state_d = WR_FILL;
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (rd_clr) begin
            full_d[rb_q] = 1'b0;
        end
        if (wr_set) begin
            full_d[wb_q] = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= WR_FILL;
            rd_state_q <= RD_IDLE;
            wi_q       <= '0;
            oidx_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            full_q     <= 2'b00;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wi_q       <= wi_d;
            oidx_q     <= oidx_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_frame_bank #(
            .ADDR_W (TOTAL_STEP),
            .WORD_W (2*DATA_WIDTH)
        ) u_bank (
            .iclk    (iclk),
            .we_i    (we && (wb_q == 1'(g))),
            .waddr_i (wi_q),
            .wdata_i ({iReal, iImag}),
            .re_i    (re && (rb_q == 1'(g))),
            .raddr_i (raddr),
            .rdata_o (rdata[g])
        );
    end

    assign sel_word       = rdata[rb_q];
    assign out_if.o_valid = valid_q;
    assign out_if.o_real  = valid_q ? sel_word[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out_if.o_imag  = valid_q ? sel_word[DATA_WIDTH-1:0] : '0;
    assign out_if.o_first = valid_q & (oidx_q == '0);
    assign out_if.o_last  = valid_q & (oidx_q == LAST_IDX);
    assign ovf            = ovf_q;
    assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_fft_frame_sink.sv
// tb/tb_fft_frame_sink.sv - directed scoreboard bench for fft_frame_sink
module tb_fft_frame_sink;
    localparam int TS = 5;
    localparam int DW = 16;
    localparam int N  = 1 << TS;

    logic          iclk  = 1'b0;
    logic          rstn  = 1'b1;
    logic          ien   = 1'b0;
    logic [DW-1:0] iReal = '0;
    logic [DW-1:0] iImag = '0;
    logic          ovf;
    logic [7:0]    drop_cnt;
    logic          ready_lvl = 1'b0;
    logic          pat_mode  = 1'b0;
    logic [1:0]    ph        = 2'd0;

    fft_frame_sink_if #(.DATA_WIDTH(DW)) sif ();

    // pattern mode drives o_ready as 1,0,0,1 repeating
    assign sif.o_ready = pat_mode ? ((ph == 2'd0) || (ph == 2'd3)) : ready_lvl;

    fft_frame_sink #(.TOTAL_STEP(TS), .DATA_WIDTH(DW)) dut (
        .iclk     (iclk),
        .rstn     (rstn),
        .ien      (ien),
        .iReal    (iReal),
        .iImag    (iImag),
        .out_if   (sif),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) ph <= ph + 2'd1;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          first;
        logic          last;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           e_m;
    int             checks   = 0;
    int             failures = 0;
    int             ovf_cnt  = 0;
    logic           prev_stall = 1'b0;
    logic [2*DW+1:0] prev_word = '0;
    wire  [2*DW+1:0] obs_word = {sif.o_real, sif.o_imag, sif.o_first, sif.o_last};

    function automatic int rev5(input int j);
        int r = 0;
        for (int b = 0; b < TS; b++) begin
            if ((j & (1 << b)) != 0) r |= 1 << (TS - 1 - b);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_frame(input int base);
        exp_t e;
        int   s;
        for (int j = 0; j < N; j++) begin
`ifdef FFT_FRAME_SINK_BITREV_EN
            s = rev5(j);
`else
            s = j;
`endif
            e.re    = DW'(base + s);
            e.im    = DW'(-(base + s));
            e.first = (j == 0);
            e.last  = (j == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int base, input bit accept);
        if (accept) push_frame(base);
        for (int k = 0; k < N; k++) begin
            ien   = 1'b1;
            iReal = DW'(base + k);
            iImag = DW'(-(base + k));
            @(posedge iclk); #1;
        end
        ien = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        int c = 0;
        while (exp_q.size() != 0 && c < limit) begin
            @(posedge iclk); #1;
            c++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(posedge iclk);
        #1;
    endtask

    task automatic wait_first(input string tag, input int limit);
        int   c    = 0;
        logic seen = 1'b0;
        while (!seen && c < limit) begin
            @(negedge iclk);
            c++;
            seen = (sif.o_valid === 1'b1) && (sif.o_first === 1'b1);
        end
        check(tag, seen, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, sif.o_valid, 0);
        check({tag, "_first"}, sif.o_first, 0);
        check({tag, "_last"},  sif.o_last,  0);
        check({tag, "_ovf"},   ovf,         0);
        check({tag, "_real"},  sif.o_real,  0);
        check({tag, "_imag"},  sif.o_imag,  0);
        check({tag, "_drop"},  drop_cnt,    0);
    endtask

    always @(negedge iclk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (ovf === 1'b1) ovf_cnt++;
            if (prev_stall) begin
                checks++;
                assert ((sif.o_valid === 1'b1) && (obs_word === prev_word)) else begin
                    failures++;
                    $error("FAIL hold observed=%h/v%b expected=%h/v1", obs_word, sif.o_valid, prev_word);
                end
            end
            if ((sif.o_valid === 1'b1) && (sif.o_ready === 1'b1)) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_xfer observed=%h expected=none", obs_word);
                end
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    checks++;
                    assert (obs_word === e_m) else begin
                        failures++;
                        $error("FAIL xfer observed=%h expected=%h", obs_word, e_m);
                    end
                end
            end
            prev_stall = (sif.o_valid === 1'b1) && (sif.o_ready !== 1'b1);
            prev_word  = obs_word;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #2 rstn = 1'b0;
        repeat (2) @(negedge iclk);
        check_reset_outputs("reset");
        @(posedge iclk); #1;
        rstn = 1'b1;

        // single frame, ready held high: latency and no bubbles
        ready_lvl = 1'b1;
        send_frame(0, 1'b1);
        wait_first("latency_first", 2);
        c = 0;
        while (!((sif.o_valid === 1'b1) && (sif.o_last === 1'b1)) && c < 40) begin
            @(negedge iclk);
            c++;
        end
        check("no_bubble", c, N - 1);
        drain("drain_single", 200);

        // ready toggling 1,0,0,1
        pat_mode = 1'b1;
        send_frame(100, 1'b1);
        drain("drain_toggle", 400);
        pat_mode = 1'b0;

        // three frames into a stalled sink: third one dropped
        ready_lvl = 1'b0;
        ovf_cnt   = 0;
        send_frame(200, 1'b1);
        send_frame(300, 1'b1);
        send_frame(400, 1'b0);
        repeat (3) @(posedge iclk);
        #1;
        check("drop_ovf_pulses", ovf_cnt, 1);
        check("drop_cnt_one", drop_cnt, 1);
        check("stall_valid", sif.o_valid, 1);
        ready_lvl = 1'b1;
        drain("drain_drop", 300);

        // back-to-back frames: third frame starts on the edge its bank is freed
        ovf_cnt = 0;
        send_frame(500, 1'b1);
        send_frame(600, 1'b1);
        send_frame(700, 1'b1);
        drain("drain_b2b", 400);
        check("b2b_ovf", ovf_cnt, 0);
        check("b2b_drop_cnt", drop_cnt, 1);

        // last write of frame B coincides with o_last transfer of frame A
        ovf_cnt = 0;
        send_frame(800, 1'b1);
        @(posedge iclk); #1;
        send_frame(900, 1'b1);
        wait_first("overlap_latency", 2);
        drain("drain_overlap", 300);
        check("overlap_ovf", ovf_cnt, 0);
        check("overlap_drop_cnt", drop_cnt, 1);

        // saturation of drop counter
        rstn = 1'b0;
        @(negedge iclk);
        check("sat_reset_drop", drop_cnt, 0);
        @(posedge iclk); #1;
        rstn      = 1'b1;
        ready_lvl = 1'b0;
        ovf_cnt   = 0;
        send_frame(1000, 1'b1);
        send_frame(1100, 1'b1);
        for (int i = 0; i < 298; i++) send_frame(2000 + i, 1'b0);
        repeat (3) @(posedge iclk);
        #1;
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_ovf_pulses", ovf_cnt, 298);
        ready_lvl = 1'b1;
        drain("drain_sat", 300);

        // reset at sample 17 of frame 2 while frame 1 streams
        send_frame(3000, 1'b1);
        for (int k = 0; k < 17; k++) begin
            ien   = 1'b1;
            iReal = DW'(3100 + k);
            iImag = DW'(-(3100 + k));
            @(posedge iclk); #1;
        end
        check("midreset_streaming", sif.o_valid, 1);
        ien  = 1'b0;
        rstn = 1'b0;
        @(negedge iclk);
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge iclk); #1;
        rstn = 1'b1;
        send_frame(4000, 1'b1);
        wait_first("after_reset_latency", 2);
        drain("drain_after_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_frame_sink.md
FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 Parameter TOTAL_STEP, default 5: log2 of frame length; N = 1<<TOTAL_STEP samples per frame.
REQ-002 Parameter DATA_WIDTH, default 16: width of each real/imag sample, two's complement.
REQ-003 iclk  input  1  clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 ien  input  1  upstream sample strobe (FFT core oen); no backpressure toward the core.
REQ-006 iReal  input  DATA_WIDTH  real sample, valid when ien=1.
REQ-007 iImag  input  DATA_WIDTH  imag sample, valid when ien=1.
REQ-008 o_valid  output  1  downstream sample valid.
REQ-009 o_ready  input  1  downstream accept; transfer = o_valid & o_ready.
REQ-010 o_real  output  DATA_WIDTH  real sample out.
REQ-011 o_imag  output  DATA_WIDTH  imag sample out.
REQ-012 o_first  output  1  high with sample index 0 of a frame.
REQ-013 o_last  output  1  high with sample index N-1 of a frame.
REQ-014 ovf  output  1  one-cycle pulse when an incoming frame is dropped.
REQ-015 drop_cnt  output  8  dropped-frame count, saturates at 255.

Function
REQ-016 Storage: two banks (ping-pong), N entries each of {real, imag}.
REQ-017 Write FSM: states FILL, DROP; write index wi counts 0..N-1, wraps to 0 after N-1.
REQ-018 FILL: each ien writes sample to current write bank at wi; at wi=N-1 bank marked full and write bank toggles, same edge.
REQ-019 Frame start (wi=0 with ien) while target bank still full: go to DROP, pulse ovf, increment drop_cnt (saturating); existing data untouched.
REQ-020 DROP: discard N samples counted by wi, return to FILL at wi=N-1; a later frame re-evaluates bank state.
REQ-021 Read FSM: states IDLE, STREAM; IDLE->STREAM when read bank full; STREAM->IDLE after the transfer with o_last, clearing that bank's full flag and toggling read bank on the same edge.
REQ-022 Latency: o_valid asserts no later than 2 cycles after the edge writing sample N-1 of a frame whose bank was empty.
REQ-023 Handshake: o_valid never drops and o_real/o_imag/o_first/o_last never change while o_valid=1 and o_ready=0.
REQ-024 Throughput: with o_ready held 1, one sample per cycle, no bubbles within a frame; next full bank streams with at most 1 idle cycle between frames.
REQ-025 Simultaneous write-full and read-clear of the same bank on one edge: clear takes effect, set also takes effect for the other bank; no frame lost.
REQ-026 Sample arriving in the cycle its bank is being freed is accepted (clear-before-check).

Reset
REQ-027 rstn low: o_valid=0, o_first=0, o_last=0, ovf=0, o_real=0, o_imag=0, drop_cnt=0, wi=0, both banks empty, FSMs to FILL/IDLE, bank pointers to 0.
REQ-028 Reset mid-frame discards partial and buffered frames; bank memory contents need no reset.

Configuration
REQ-029 Macro FFT_FRAME_SINK_BITREV_EN defined: read address is bit-reverse(TOTAL_STEP bits) of output index, converting bit-reversed FFT order to natural order.
REQ-030 Macro undefined: read address equals output index (pass-through order); all other behaviour identical.

Structure
REQ-031 Shared package holds write/read FSM state encodings and a bit-reverse function parameterised by TOTAL_STEP.
REQ-032 Sub-module fft_frame_bank: one dual-port bank (1 write, 1 registered read port), instantiated twice.

Verification
REQ-033 N=32, frame samples real=k, imag=-k, o_ready=1 -> 32 transfers, o_first at k=0, o_last at k=31, values match (bit-reversed index k->rev5(k) order with macro).
REQ-034 Three back-to-back frames, o_ready=0 -> frames 1,2 buffered, frame 3 dropped: ovf pulses once, drop_cnt=1; then o_ready=1 -> frames 1,2 out in order.
REQ-035 o_ready toggled 1,0,0,1 repeatedly -> output held stable during stalls, all 32 samples delivered once, in order.
REQ-036 300 frames with o_ready=0 after first two -> drop_cnt saturates at 255.
REQ-037 rstn asserted at sample 17 of frame 2 with frame 1 streaming -> all outputs 0 next cycle; fresh frame after release streams correctly.
REQ-038 Last sample of frame written on same edge as o_last transfer of other bank -> no drop, ovf=0, next frame streams within 2 cycles.
